// File: rtl/stack_addr_unit_if.sv
// Memory-side bus between the stack address unit and the bus interface unit:
// one req/ack word transaction at a time.
interface stack_addr_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stack_addr_unit.sv
// Stack pointer owner and PUSH/POP sequencer: adjusts SP, forms SS*16+SP and runs one
// req/ack bus transaction per operation. Optional macro STACK_FAULT_CHECK_EN adds o_stk_fault.
module stack_addr_unit #(
  parameter logic [15:0] SP_RESET = 16'h0000,
  parameter logic [15:0] SP_STEP  = 16'd2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_ss_in,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [15:0] i_wr_data,
  input  logic        i_sp_ld,
  input  logic [15:0] i_sp_d,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_sp_q,
  output logic        o_busy,
  output logic        o_done,
`ifdef STACK_FAULT_CHECK_EN
  output logic        o_stk_fault,
`endif
  stack_addr_unit_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_ADJ,
    S_MEM_ACCESS,
    S_POP_ADJ,
    S_FINISH
  } state_t;

  state_t      r_state;
  logic [15:0] r_sp;
  logic [15:0] r_ss;
  logic [15:0] r_wdata;
  logic [15:0] r_rd_data;
  logic [19:0] r_addr;
  logic        r_req;
  logic        r_we;
  logic        r_busy;
  logic        r_done;
`ifdef STACK_FAULT_CHECK_EN
  logic        r_fault;
`endif

  logic [15:0] w_sp_dec;
  logic [15:0] w_sp_inc;
  logic [19:0] w_addr_push;
  logic [19:0] w_addr_pop;

  // Address sums are 20 bits wide, so any carry out of bit 19 is dropped.
  assign w_sp_dec    = r_sp - SP_STEP;
  assign w_sp_inc    = r_sp + SP_STEP;
  assign w_addr_push = {r_ss, 4'h0} + {4'h0, w_sp_dec};
  assign w_addr_pop  = {i_ss_in, 4'h0} + {4'h0, r_sp};

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; blocking ones would let later statements see new values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_sp      <= SP_RESET;
      r_ss      <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_addr    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef STACK_FAULT_CHECK_EN
      r_fault   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_sp_ld) begin
            r_sp <= i_sp_d;
`ifdef STACK_FAULT_CHECK_EN
            r_fault <= 1'b0;
`endif
          end else if (i_push) begin
            r_ss    <= i_ss_in;
            r_wdata <= i_wr_data;
            r_busy  <= 1'b1;
            r_state <= S_PUSH_ADJ;
`ifdef STACK_FAULT_CHECK_EN
            if (r_sp < SP_STEP) r_fault <= 1'b1;
`endif
          end else if (i_pop) begin
            r_addr  <= w_addr_pop;
            r_we    <= 1'b0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_MEM_ACCESS;
`ifdef STACK_FAULT_CHECK_EN
            if (r_sp > (16'hFFFF - SP_STEP)) r_fault <= 1'b1;
`endif
          end
        end

        // Pre-decrement: the write goes to the already-adjusted SP.
        S_PUSH_ADJ: begin
          r_sp    <= w_sp_dec;
          r_addr  <= w_addr_push;
          r_we    <= 1'b1;
          r_req   <= 1'b1;
          r_state <= S_MEM_ACCESS;
        end

        S_MEM_ACCESS: begin
          if (mem.mem_ack) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_rd_data <= mem.mem_rdata;
              r_state   <= S_POP_ADJ;
            end
          end
        end

        S_POP_ADJ: begin
          r_sp    <= w_sp_inc;
          r_done  <= 1'b1;
          r_state <= S_FINISH;
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign o_rd_data     = r_rd_data;
  assign o_sp_q        = r_sp;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
`ifdef STACK_FAULT_CHECK_EN
  assign o_stk_fault   = r_fault;
`endif

endmodule

// File: tb/tb_stack_addr_unit.sv
// Self-checking bench for stack_addr_unit: per-cycle compare against a transaction-level model,
// directed scenarios with literal expectations, then randomized operations with bus-side noise.
module tb_stack_addr_unit;

  localparam int SP_STEP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ss_in, i_wr_data, i_sp_d;
  logic        i_push, i_pop, i_sp_ld;
  logic [15:0] o_rd_data, o_sp_q;
  logic        o_busy, o_done;
  logic        stk_fault;

  stack_addr_unit_if mem();

  stack_addr_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ss_in     (i_ss_in),
    .i_push      (i_push),
    .i_pop       (i_pop),
    .i_wr_data   (i_wr_data),
    .i_sp_ld     (i_sp_ld),
    .i_sp_d      (i_sp_d),
    .o_rd_data   (o_rd_data),
    .o_sp_q      (o_sp_q),
    .o_busy      (o_busy),
    .o_done      (o_done),
`ifdef STACK_FAULT_CHECK_EN
    .o_stk_fault (stk_fault),
`endif
    .mem         (mem)
  );

`ifndef STACK_FAULT_CHECK_EN
  assign stk_fault = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state (values after the last completed operation)
  int m_sp;
  int m_rd;
  bit m_fault;

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic [15:0] e_sp, e_rd, e_wdata;
  logic [19:0] e_addr;
  logic        e_busy, e_done, e_req, e_we, e_fault;

  logic [19:0] last_addr;
  logic [15:0] last_wdata;
  logic        last_we;

  always @(negedge clk) begin
    if (chk_en) begin
      check("sp_q", 32'(o_sp_q), 32'(e_sp));
      check("rd_data", 32'(o_rd_data), 32'(e_rd));
      check("busy", 32'(o_busy), 32'(e_busy));
      check("done", 32'(o_done), 32'(e_done));
      check("mem_req", 32'(mem.mem_req), 32'(e_req));
`ifdef STACK_FAULT_CHECK_EN
      check("stk_fault", 32'(stk_fault), 32'(e_fault));
`endif
      if (e_req) begin
        check("mem_we", 32'(mem.mem_we), 32'(e_we));
        check("mem_addr", 32'(mem.mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", 32'(mem.mem_wdata), 32'(e_wdata));
      end
    end
    if (mem.mem_req) begin
      last_addr  = mem.mem_addr;
      last_wdata = mem.mem_wdata;
      last_we    = mem.mem_we;
    end
  end

  function automatic logic [19:0] phys(input int ss, input int sp);
    return 20'((ss * 16 + sp) % (1 << 20));
  endfunction

  // Apply one command in IDLE, then walk the operation cycle by cycle.
  // Cycle c is the period after the c-th rising edge following acceptance.
  task automatic run_cmd(input bit push, input bit pop, input bit ld, input logic [15:0] sp_d,
                         input logic [15:0] wr, input logic [15:0] ss, input int waits,
                         input logic [15:0] rdv, input bit noise);
    bit is_push, is_pop;
    int sp0, sp1, n, mlo, mhi;
    logic [19:0] addr;
    is_push = !ld && push;
    is_pop  = !ld && !push && pop;
    sp0 = m_sp; sp1 = m_sp;
    n = 0; mlo = 1; mhi = 0; addr = '0;
    i_push = push; i_pop = pop; i_sp_ld = ld;
    i_sp_d = sp_d; i_wr_data = wr; i_ss_in = ss;
    if (ld) begin
      m_sp = int'(sp_d); m_fault = 1'b0; sp1 = m_sp; sp0 = m_sp;
    end else if (is_push) begin
      sp1 = (sp0 - SP_STEP + 65536) % 65536;
      addr = phys(int'(ss), sp1);
      if (sp0 < SP_STEP) m_fault = 1'b1;
      n = 3 + waits; mlo = 2; mhi = 2 + waits;
    end else if (is_pop) begin
      sp1 = (sp0 + SP_STEP) % 65536;
      addr = phys(int'(ss), sp0);
      if (sp0 > 65535 - SP_STEP) m_fault = 1'b1;
      n = 3 + waits; mlo = 1; mhi = 1 + waits;
    end
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clk); #1;
      i_push = 1'b0; i_pop = 1'b0; i_sp_ld = 1'b0;
      if (noise && c <= n) begin
        i_push = 1'($urandom); i_pop = 1'($urandom); i_sp_ld = 1'($urandom);
        i_sp_d = 16'($urandom); i_ss_in = 16'($urandom); i_wr_data = 16'($urandom);
      end
      mem.mem_ack   = (c == mhi) || (noise && (c < mlo || c > mhi) && $urandom_range(0, 1) == 1);
      mem.mem_rdata = (c == mhi) ? rdv : 16'($urandom);
      e_busy  = (c <= n);
      e_done  = (n > 0) && (c == n);
      e_req   = (c >= mlo) && (c <= mhi);
      e_we    = is_push;
      e_addr  = addr;
      e_wdata = wr;
      e_fault = m_fault;
      if (is_push)     e_sp = 16'((c >= 2) ? sp1 : sp0);
      else if (is_pop) e_sp = 16'((c >= n) ? sp1 : sp0);
      else             e_sp = 16'(m_sp);
      if (is_pop && c > mhi) e_rd = rdv;
      else                   e_rd = 16'(m_rd);
    end
    m_sp = sp1;
    if (is_pop) m_rd = int'(rdv);
    mem.mem_ack = 1'b0;
  endtask

  task automatic reset_mid_pop();
    chk_en = 1'b0;
    i_pop = 1'b1; i_ss_in = 16'h3000;
    @(posedge clk); #1;
    i_pop = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req_before", 32'(mem.mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_req", 32'(mem.mem_req), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_done", 32'(o_done), 32'd0);
    check("rst_mid_sp", 32'(o_sp_q), 32'h0000);
    check("rst_mid_rd", 32'(o_rd_data), 32'h0000);
    mem.mem_ack = 1'b1; mem.mem_rdata = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem.mem_ack = 1'b0;
      check("late_ack_busy", 32'(o_busy), 32'd0);
      check("late_ack_done", 32'(o_done), 32'd0);
      check("late_ack_rd", 32'(o_rd_data), 32'h0000);
    end
    m_sp = 0; m_rd = 0; m_fault = 1'b0;
    e_sp = '0; e_rd = '0; e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_fault = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    i_push = 1'b0; i_pop = 1'b0; i_sp_ld = 1'b0;
    i_sp_d = '0; i_wr_data = '0; i_ss_in = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    m_sp = 0; m_rd = 0; m_fault = 1'b0;
    e_sp = '0; e_rd = '0; e_wdata = '0; e_addr = '0;
    e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_we = 1'b0; e_fault = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_sp", 32'(o_sp_q), 32'h0000);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_req", 32'(mem.mem_req), 32'd0);
    check("reset_rd", 32'(o_rd_data), 32'h0000);
    check("reset_addr", 32'(mem.mem_addr), 32'h0);
    chk_en = 1'b1;

    // Push ABCD at SS=2000, SP=0100, immediate ack
    run_cmd(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0, 16'h0, 0, 16'h0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'hABCD, 16'h2000, 0, 16'h0, 1'b0);
    check("push_sp", 32'(o_sp_q), 32'h00FE);
    check("push_addr", 32'(last_addr), 32'h200FE);
    check("push_wdata", 32'(last_wdata), 32'hABCD);
    check("push_we", 32'(last_we), 32'd1);

    // Pop with three wait cycles
    run_cmd(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h2000, 3, 16'h1234, 1'b0);
    check("pop_rd", 32'(o_rd_data), 32'h1234);
    check("pop_sp", 32'(o_sp_q), 32'h0100);
    check("pop_addr", 32'(last_addr), 32'h200FE);
    check("pop_we", 32'(last_we), 32'd0);

    // Push wrap at SP=0000 with SS=FFFF
    run_cmd(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0, 0, 16'h0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h5A5A, 16'hFFFF, 1, 16'h0, 1'b0);
    check("wrap_sp", 32'(o_sp_q), 32'hFFFE);
    check("wrap_addr", 32'(last_addr), 32'h0FFEE);
`ifdef STACK_FAULT_CHECK_EN
    check("wrap_fault", 32'(stk_fault), 32'd1);
`endif

    // Pop wrap from FFFE back to 0000
    run_cmd(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0010, 0, 16'h7777, 1'b1);
    check("popwrap_sp", 32'(o_sp_q), 32'h0000);

    // Priority: SP_LD beats PUSH/POP; then PUSH beats POP
    run_cmd(1'b1, 1'b1, 1'b1, 16'h0200, 16'h1111, 16'h4000, 0, 16'h0, 1'b0);
    check("prio_ld_sp", 32'(o_sp_q), 32'h0200);
    run_cmd(1'b1, 1'b1, 1'b0, 16'h0, 16'h2222, 16'h4000, 0, 16'h0, 1'b0);
    check("prio_push_sp", 32'(o_sp_q), 32'h01FE);
    check("prio_push_addr", 32'(last_addr), 32'h401FE);
    check("prio_push_we", 32'(last_we), 32'd1);

    reset_mid_pop();

    // Randomized operations with ignored commands/acks injected while busy
    for (int k = 0; k < 250; k++) begin
      logic [15:0] sp_d;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: sp_d = 16'h0000;
        1: sp_d = 16'hFFFE;
        2: sp_d = 16'hFFFF;
        3: sp_d = 16'h0001;
        default: sp_d = 16'($urandom);
      endcase
      run_cmd(1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, sp_d,
              16'($urandom), 16'($urandom), $urandom_range(0, 3), 16'($urandom), 1'b1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_addr_unit.md
Name: stack_addr_unit

Overview:
Stack pointer and stack-access sequencer that consumes the 16-bit SS segment value from the SS segment register and owns SP. It executes PUSH/POP word operations: adjusts SP, forms the 20-bit physical address SS*16+SP, and runs one req/ack memory transaction per operation. It sits between the segment register file and the bus interface unit.

Parameters:
SP_RESET, 16'h0000, SP value loaded on reset.
SP_STEP, 2, SP decrement/increment per operation (word stack).

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  synchronous reset, active-high.
SS_IN  in  16  current SS segment value.
PUSH  in  1  push command, sampled in IDLE only.
POP  in  1  pop command, sampled in IDLE only.
WR_DATA  in  16  push data, captured when PUSH is accepted.
SP_LD  in  1  direct SP load, effective in IDLE only.
SP_D  in  16  SP load value.
MEM_RDATA  in  16  read data from bus unit.
MEM_ACK  in  1  bus transaction complete.
MEM_REQ  out  1  bus request.
MEM_WE  out  1  1=write (push), 0=read (pop).
MEM_ADDR  out  20  physical address.
MEM_WDATA  out  16  write data.
RD_DATA  out  16  popped word, held until next pop completes.
SP_Q  out  16  current SP.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, CLK edge with RST=1, any state): state=IDLE, SP=SP_RESET; MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RD_DATA, BUSY, DONE all 0. In-flight transaction is abandoned; MEM_REQ is low from the following cycle.
- States: IDLE, PUSH_ADJ, MEM_ACCESS, POP_ADJ, FINISH.
- IDLE priority: SP_LD > PUSH > POP. SP_LD: SP<=SP_D next cycle; PUSH/POP in the same cycle are dropped. PUSH: latch WR_DATA and SS_IN -> PUSH_ADJ. POP: latch SS_IN -> MEM_ACCESS (read).
- PUSH_ADJ: SP<=SP-SP_STEP (mod 2^16) -> MEM_ACCESS (write).
- MEM_ACCESS: MEM_REQ=1, MEM_WE per op, MEM_ADDR=({SS_latched,4'h0}+{4'h0,SP}) mod 2^20, MEM_WDATA=latched data; all held stable until MEM_ACK=1. On ACK: push -> FINISH; pop -> RD_DATA<=MEM_RDATA, -> POP_ADJ. MEM_REQ deasserts the cycle after ACK.
- POP_ADJ: SP<=SP+SP_STEP (mod 2^16) -> FINISH.
- FINISH: DONE=1 for exactly one cycle -> IDLE.
- MEM_ACK outside MEM_ACCESS ignored. PUSH/POP/SP_LD outside IDLE ignored (not queued). SS_IN changes after acceptance do not affect the in-flight address.
- Latency with ACK asserted in the first MEM_ACCESS cycle: command accepted at edge 0, DONE high in cycle 3 for both push and pop; each wait cycle on ACK adds 1.
- Wrap: SP 0x0000 push -> 0xFFFE; SP 0xFFFE pop -> 0x0000; address sum carry beyond bit 19 is discarded.

Optional Feature:
STACK_FAULT_CHECK_EN: when defined, adds output STK_FAULT (1 bit, reset 0). Set on accepting PUSH with SP<SP_STEP (underflow wrap) or POP with SP>16'hFFFF-SP_STEP (overflow wrap). Sticky until RST or SP_LD. The operation still completes with wrap. When undefined, the port is absent and wrap is silent.

Test Plan:
Reset: RST=1 for 1 cycle -> SP_Q=0000, BUSY=0, DONE=0, MEM_REQ=0, RD_DATA=0000.
Push: SP_LD SP_D=0100, SS_IN=2000, PUSH WR_DATA=ABCD, ACK immediate -> MEM_ADDR=200FE, MEM_WE=1, MEM_WDATA=ABCD, SP_Q=00FE, DONE in cycle 3.
Pop after push, ACK after 3 wait cycles, MEM_RDATA=1234 -> MEM_ADDR=200FE, MEM_WE=0, RD_DATA=1234, SP_Q=0100, DONE in cycle 6.
Wrap: SS_IN=FFFF, SP=0000, PUSH -> SP_Q=FFFE, MEM_ADDR=0FFEE (carry dropped); STK_FAULT=1 when macro defined.
Simultaneous PUSH+POP+SP_LD (SP_D=0200) in IDLE -> SP_Q=0200, no MEM_REQ; then PUSH+POP together -> push executed only.
RST asserted in MEM_ACCESS before ACK -> next cycle IDLE, MEM_REQ=0, SP=SP_RESET, no DONE pulse; late MEM_ACK ignored.
